oled_i2c_target: RTL and testbench

I2C target (slave) endpoint answering at a 7-bit chip address and exposing received traffic as a simple register-write port. It is the responder to the OLED I2C master controller. It lets the board emulate an OLED controller for loopback tests, and lets an external master load configuration into a local register file. The bus pins connect to the top-level open-drain pads alongside the master.

---
 rtl/oled_i2c_target.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_oled_i2c_target.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_i2c_target.sv
// oled_i2c_target: I2C target endpoint answering at CHIP_ADDR. Received write
// traffic is presented as a register-write strobe (pointer + data). The
// optional read path fetches bytes from an external register file.
//
// Optional feature macro: I2C_TARGET_READ_EN
//   defined   -> read transactions supported (rd_en / rd_addr / rd_data live)
//   undefined -> R=1 addresses are NACKed, rd_en / rd_addr tied to 0
//
// Ports:
//   clk, reset        system clock, async active-low reset
//   scl_in, sda_in    bus pad levels (clk must run >= 16x SCL)
//   sda_out           constant 0 (open-drain low level)
//   sda_oen           1 = pull SDA low, 0 = release
//   busy              addressed transaction in progress (ACKed address to STOP)
//   wr_en             one-cycle write strobe with wr_addr / wr_data
//   rd_en, rd_addr    one-cycle read-fetch strobe and fetch address
//   rd_data           fetched register data, captured the cycle after rd_en
module oled_i2c_target #(
  parameter logic [6:0] CHIP_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oen,
  output logic       busy,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
`ifdef I2C_TARGET_READ_EN
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
`endif
    IGNORE    = 4'd9
  } state_e;

  // [0],[1] synchronize, [2] is the previous synchronized level for edge detection
  logic [SYNC_W-1:0] scl_sync_q;
  logic [SYNC_W-1:0] sda_sync_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic [BYTE_W-1:0]  ptr_q, ptr_d;
  logic               sda_oen_q, sda_oen_d;
  logic               busy_q, busy_d;
  logic               wr_en_q, wr_en_d;
  logic [BYTE_W-1:0]  wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]  wr_data_q, wr_data_d;
`ifdef I2C_TARGET_READ_EN
  logic               rd_en_q, rd_en_d;
  logic               fetch_q, fetch_d;
  logic [BYTE_W-1:0]  rd_addr_q, rd_addr_d;
`endif

  logic scl_s_c, scl_p_c, sda_s_c, sda_p_c;
  logic scl_rise_c, scl_fall_c, start_c, stop_c, byte_done_c;
  logic [BYTE_W-1:0] byte_in_c;

  // Bus event decode on synchronized levels
  always_comb begin
    scl_s_c     = scl_sync_q[1];
    scl_p_c     = scl_sync_q[2];
    sda_s_c     = sda_sync_q[1];
    sda_p_c     = sda_sync_q[2];
    scl_rise_c  = scl_s_c & ~scl_p_c;
    scl_fall_c  = ~scl_s_c & scl_p_c;
    start_c     = scl_s_c & scl_p_c & sda_p_c & ~sda_s_c;
    stop_c      = scl_s_c & scl_p_c & ~sda_p_c & sda_s_c;
    byte_in_c   = {shift_q[6:0], sda_s_c};
    byte_done_c = (cnt_q == CNT_W'(BYTE_W));
  end

  // Next-state and output logic; START/STOP override any bit operation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oen_d = sda_oen_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef I2C_TARGET_READ_EN
    rd_en_d   = 1'b0;
    fetch_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
`endif

    if (stop_c) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sda_oen_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_c) begin
      state_d   = ADDR;
      cnt_d     = '0;
      sda_oen_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise_c && !byte_done_c) begin
            shift_d = byte_in_c;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (scl_fall_c && byte_done_c) begin
            cnt_d = '0;
            if (shift_q[7:1] != CHIP_ADDR) begin
              state_d = IGNORE;
`ifndef I2C_TARGET_READ_EN
            end else if (shift_q[0]) begin
              // reads not built: leave SDA released so the master sees NACK
              state_d = IGNORE;
`endif
            end else begin
              state_d   = ADDR_ACK;
              sda_oen_d = 1'b1;
              busy_d    = 1'b1;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall_c) begin
            sda_oen_d = 1'b0;
            state_d   = REG;
`ifdef I2C_TARGET_READ_EN
            if (shift_q[0]) begin
              state_d   = RDATA;
              rd_en_d   = 1'b1;
              rd_addr_d = ptr_q;
            end
`endif
          end
        end

        REG: begin
          if (scl_rise_c && !byte_done_c) begin
            shift_d = byte_in_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BYTE_W - 1)) ptr_d = byte_in_c;
          end else if (scl_fall_c && byte_done_c) begin
            cnt_d     = '0;
            state_d   = REG_ACK;
            sda_oen_d = 1'b1;
          end
        end

        REG_ACK: begin
          if (scl_fall_c) begin
            sda_oen_d = 1'b0;
            state_d   = WDATA;
          end
        end

        WDATA: begin
          if (scl_rise_c && !byte_done_c) begin
            shift_d = byte_in_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in_c;
            end
          end else if (scl_fall_c && byte_done_c) begin
            cnt_d     = '0;
            state_d   = WDATA_ACK;
            sda_oen_d = 1'b1;
          end
        end

        WDATA_ACK: begin
          if (scl_fall_c) begin
            sda_oen_d = 1'b0;
            ptr_d     = ptr_q + 8'd1;
            state_d   = WDATA;
          end
        end

`ifdef I2C_TARGET_READ_EN
        RDATA: begin
          if (fetch_q) begin
            // fetched byte arrives: present MSB during the current SCL-low phase
            shift_d   = rd_data;
            sda_oen_d = ~rd_data[7];
            cnt_d     = '0;
          end else if (scl_fall_c) begin
            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
              state_d   = RDATA_ACK;
              sda_oen_d = 1'b0;
              cnt_d     = '0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oen_d = ~shift_q[6];
              cnt_d     = cnt_q + CNT_W'(1);
            end
          end
        end

        RDATA_ACK: begin
          // cnt == BYTE_W marks a sampled master ACK awaiting the SCL fall
          if (scl_rise_c) begin
            if (sda_s_c) state_d = IGNORE;
            else         cnt_d   = CNT_W'(BYTE_W);
          end else if (scl_fall_c && byte_done_c) begin
            cnt_d     = '0;
            ptr_d     = ptr_q + 8'd1;
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_q + 8'd1;
            state_d   = RDATA;
          end
        end
`endif

        IDLE, IGNORE: begin
          sda_oen_d = 1'b0;
        end

        default: begin
          state_d   = IDLE;
          sda_oen_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; synchronizers reset to the idle bus level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oen_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef I2C_TARGET_READ_EN
      rd_en_q    <= 1'b0;
      fetch_q    <= 1'b0;
      rd_addr_q  <= '0;
`endif
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_W-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_W-2:0], sda_in};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oen_q  <= sda_oen_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef I2C_TARGET_READ_EN
      rd_en_q    <= rd_en_d;
      fetch_q    <= fetch_d;
      rd_addr_q  <= rd_addr_d;
`endif
    end
  end

  assign sda_out = 1'b0;
  assign sda_oen = sda_oen_q;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef I2C_TARGET_READ_EN
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
`else
  logic unused_rd_data_c;
  assign unused_rd_data_c = ^rd_data;
  assign rd_en   = 1'b0;
  assign rd_addr = '0;
`endif

endmodule

// File: tb/tb_oled_i2c_target.sv
// Directed testbench for oled_i2c_target: bit-banged I2C master with
// open-drain bus resolution, negedge monitors logging strobes, and one task
// per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_oled_i2c_target;

  localparam int H = 20;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_out, sda_oen, busy, wr_en, rd_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int checks;
  int passed;

  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  int          oen_hi;
  int          busy_hi;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oen;
  assign rd_data = (rd_addr == 8'h05) ? 8'h3C :
                   (rd_addr == 8'h06) ? 8'h81 : 8'hEE;

  oled_i2c_target #(.CHIP_ADDR(7'h3C)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl_in  (scl_m),
    .sda_in  (sda_bus),
    .sda_out (sda_out),
    .sda_oen (sda_oen),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (rd_en) rd_log.push_back(rd_addr);
    if (sda_oen) oen_hi++;
    if (busy) busy_hi++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    wait_clk(4);
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(4);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(4);
    sda_m = b;    wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic v);
    wait_clk(4);
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H / 2);
    v = sda_bus;  wait_clk(H / 2);
    scl_m = 1'b0;
  endtask

  // returns the 9th-bit level: 0 = ACK, 1 = NACK
  task automatic write_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(nack);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    @(negedge clk);
    checks++; if (sda_oen !== 1'b0) $display("FAIL reset_sda_oen got %b want 0", sda_oen); else passed++;
    checks++; if (sda_out !== 1'b0) $display("FAIL reset_sda_out got %b want 0", sda_out); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else passed++;
    checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", rd_en); else passed++;
    checks++; if (wr_addr !== 8'h00) $display("FAIL reset_wr_addr got %h want 00", wr_addr); else passed++;
    checks++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data got %h want 00", wr_data); else passed++;
    checks++; if (rd_addr !== 8'h00) $display("FAIL reset_rd_addr got %h want 00", rd_addr); else passed++;
    reset = 1'b1;
    wait_clk(10);
    @(negedge clk);
    checks++; if (sda_oen !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset_idle got oen=%b busy=%b want 0/0", sda_oen, busy); else passed++;
  endtask

  task automatic test_write_burst();
    int w0;
    logic n0, n1, n2, n3;
    logic [15:0] got;
    w0 = wr_log.size();
    bus_start();
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL burst_busy_before_addr got %b want 0", busy); else passed++;
    write_byte(8'h78, n0);
    checks++; if (busy !== 1'b1) $display("FAIL burst_busy_after_ack got %b want 1", busy); else passed++;
    write_byte(8'h10, n1);
    write_byte(8'hAE, n2);
    write_byte(8'hD5, n3);
    checks++; if ({n0, n1, n2, n3} !== 4'b0000) $display("FAIL burst_acks got %b want 0000", {n0, n1, n2, n3}); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL burst_busy_before_stop got %b want 1", busy); else passed++;
    bus_stop();
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL burst_busy_after_stop got %b want 0", busy); else passed++;
    checks++; if (wr_log.size() - w0 != 2) $display("FAIL burst_wr_count got %0d want 2", wr_log.size() - w0); else passed++;
    got = (wr_log.size() > w0) ? wr_log[w0] : 16'hxxxx;
    checks++; if (got !== 16'h10AE) $display("FAIL burst_write0 got %h want 10AE", got); else passed++;
    got = (wr_log.size() > w0 + 1) ? wr_log[w0 + 1] : 16'hxxxx;
    checks++; if (got !== 16'h11D5) $display("FAIL burst_write1 got %h want 11D5", got); else passed++;
    checks++; if ({wr_addr, wr_data} !== 16'h11D5) $display("FAIL burst_hold got %h want 11D5", {wr_addr, wr_data}); else passed++;
  endtask

  task automatic test_wrong_addr();
    int w0, o0, b0;
    logic n0, n1;
    w0 = wr_log.size(); o0 = oen_hi; b0 = busy_hi;
    bus_start();
    write_byte(8'h7A, n0);
    write_byte(8'h00, n1);
    bus_stop();
    @(negedge clk);
    checks++; if ({n0, n1} !== 2'b11) $display("FAIL wrong_addr_nacks got %b want 11", {n0, n1}); else passed++;
    checks++; if (oen_hi - o0 != 0) $display("FAIL wrong_addr_oen got %0d cycles want 0", oen_hi - o0); else passed++;
    checks++; if (busy_hi - b0 != 0) $display("FAIL wrong_addr_busy got %0d cycles want 0", busy_hi - b0); else passed++;
    checks++; if (wr_log.size() - w0 != 0) $display("FAIL wrong_addr_wr got %0d want 0", wr_log.size() - w0); else passed++;
  endtask

  task automatic test_wrap();
    int w0;
    logic n0, n1, n2, n3;
    logic [15:0] got;
    w0 = wr_log.size();
    bus_start();
    write_byte(8'h78, n0);
    write_byte(8'hFF, n1);
    write_byte(8'h11, n2);
    write_byte(8'h22, n3);
    bus_stop();
    @(negedge clk);
    checks++; if ({n0, n1, n2, n3} !== 4'b0000) $display("FAIL wrap_acks got %b want 0000", {n0, n1, n2, n3}); else passed++;
    checks++; if (wr_log.size() - w0 != 2) $display("FAIL wrap_wr_count got %0d want 2", wr_log.size() - w0); else passed++;
    got = (wr_log.size() > w0) ? wr_log[w0] : 16'hxxxx;
    checks++; if (got !== 16'hFF11) $display("FAIL wrap_write0 got %h want FF11", got); else passed++;
    got = (wr_log.size() > w0 + 1) ? wr_log[w0 + 1] : 16'hxxxx;
    checks++; if (got !== 16'h0022) $display("FAIL wrap_write1 got %h want 0022", got); else passed++;
  endtask

`ifdef I2C_TARGET_READ_EN
  task automatic test_read();
    int w0, r0;
    logic n0, n1, n2;
    logic [7:0] b0, b1, got;
    w0 = wr_log.size(); r0 = rd_log.size();
    bus_start();
    write_byte(8'h78, n0);
    write_byte(8'h05, n1);
    bus_start();
    write_byte(8'h79, n2);
    read_byte(b0);
    write_bit(1'b0);
    read_byte(b1);
    write_bit(1'b1);
    wait_clk(8);
    @(negedge clk);
    checks++; if (sda_oen !== 1'b0) $display("FAIL read_released_after_nack got %b want 0", sda_oen); else passed++;
    bus_stop();
    @(negedge clk);
    checks++; if ({n0, n1, n2} !== 3'b000) $display("FAIL read_acks got %b want 000", {n0, n1, n2}); else passed++;
    checks++; if (b0 !== 8'h3C) $display("FAIL read_byte0 got %h want 3C", b0); else passed++;
    checks++; if (b1 !== 8'h81) $display("FAIL read_byte1 got %h want 81", b1); else passed++;
    checks++; if (rd_log.size() - r0 != 2) $display("FAIL read_rd_count got %0d want 2", rd_log.size() - r0); else passed++;
    got = (rd_log.size() > r0) ? rd_log[r0] : 8'hxx;
    checks++; if (got !== 8'h05) $display("FAIL read_rd_addr0 got %h want 05", got); else passed++;
    got = (rd_log.size() > r0 + 1) ? rd_log[r0 + 1] : 8'hxx;
    checks++; if (got !== 8'h06) $display("FAIL read_rd_addr1 got %h want 06", got); else passed++;
    checks++; if (wr_log.size() - w0 != 0) $display("FAIL read_no_write got %0d want 0", wr_log.size() - w0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL read_busy_after_stop got %b want 0", busy); else passed++;
  endtask
`else
  task automatic test_read_nack();
    int r0, o0;
    logic n0;
    r0 = rd_log.size(); o0 = oen_hi;
    bus_start();
    write_byte(8'h79, n0);
    bus_stop();
    @(negedge clk);
    checks++; if (n0 !== 1'b1) $display("FAIL read_off_nack got %b want 1", n0); else passed++;
    checks++; if (oen_hi - o0 != 0) $display("FAIL read_off_oen got %0d cycles want 0", oen_hi - o0); else passed++;
    checks++; if (rd_log.size() - r0 != 0) $display("FAIL read_off_rd_en got %0d want 0", rd_log.size() - r0); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    int w0;
    logic n0, n1, n2, n3, n4;
    logic [15:0] got;
    w0 = wr_log.size();
    bus_start();
    write_byte(8'h78, n0);
    write_byte(8'h20, n1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before_reset got %b want 1", busy); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (sda_oen !== 1'b0) $display("FAIL mid_oen_in_reset got %b want 0", sda_oen); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy_in_reset got %b want 0", busy); else passed++;
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(10);
    @(negedge clk);
    reset = 1'b1;
    wait_clk(10);
    checks++; if (wr_log.size() - w0 != 0) $display("FAIL mid_no_partial_write got %0d want 0", wr_log.size() - w0); else passed++;
    bus_start();
    write_byte(8'h78, n2);
    write_byte(8'h30, n3);
    write_byte(8'h5A, n4);
    bus_stop();
    @(negedge clk);
    checks++; if ({n0, n1, n2, n3, n4} !== 5'b00000) $display("FAIL mid_acks got %b want 00000", {n0, n1, n2, n3, n4}); else passed++;
    checks++; if (wr_log.size() - w0 != 1) $display("FAIL mid_wr_count got %0d want 1", wr_log.size() - w0); else passed++;
    got = (wr_log.size() > w0) ? wr_log[w0] : 16'hxxxx;
    checks++; if (got !== 16'h305A) $display("FAIL mid_write got %h want 305A", got); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    oen_hi = 0;
    busy_hi = 0;
    test_reset();
    test_write_burst();
    test_wrong_addr();
    test_wrap();
`ifdef I2C_TARGET_READ_EN
    test_read();
`else
    test_read_nack();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
